// File: rtl/uart_cmd_router_pkg.sv
// Shared types and constants for the UART command router.
// Mode encodings, stream framing constants and FSM states.
package cube_pkg;

   localparam int         FRAME_BYTES    = 64;
   localparam int         TIMEOUT_CYCLES = 100000;
   localparam logic [7:0] SYNC_BYTE      = 8'hFF;

   typedef enum logic [3:0] {
      MODE_OFF       = 4'd0,
      MODE_ANIM_LOOP = 4'd1,
      MODE_ANIM_SEL  = 4'd2,
      MODE_STREAM    = 4'd3,
      MODE_PLANE_MSG = 4'd4,
      MODE_ALL_ON    = 4'd5,
      MODE_ANIM_DB   = 4'd15
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

endpackage

// File: rtl/uart_cmd_router_if.sv
// Byte stream in, config forward and frame buffer write out.
// master = upstream/environment side, slave = router side.
interface uart_cmd_router_if #(
   parameter int ADDR_W = 6
);

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              buf_ready;
   logic [7:0]        cfg_byte;
   logic              cfg_valid;
   logic              buf_wr_en;
   logic [ADDR_W-1:0] buf_wr_addr;
   logic [7:0]        buf_wr_data;
   logic              frame_commit;
   logic              frame_abort;

   modport master (
      output rx_data,
      output rx_valid,
      output buf_ready,
      input  cfg_byte,
      input  cfg_valid,
      input  buf_wr_en,
      input  buf_wr_addr,
      input  buf_wr_data,
      input  frame_commit,
      input  frame_abort
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  buf_ready,
      output cfg_byte,
      output cfg_valid,
      output buf_wr_en,
      output buf_wr_addr,
      output buf_wr_data,
      output frame_commit,
      output frame_abort
   );

endinterface

// File: rtl/uart_cmd_router_idle_timer.sv
// Saturating idle counter between stream payload bytes.
// expired_o is high while the count sits at TIMEOUT_CYCLES-1.
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] SAT  = '1;

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // clear dominates; otherwise count up and hold at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != SAT)) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_router.sv
// Routes UART bytes to config space or the frame buffer.
// Sequences 64-byte stream frames with commit/abort pulses.
module uart_cmd_router #(
   parameter int         FRAME_BYTES    = cube_pkg::FRAME_BYTES,
   parameter int         TIMEOUT_CYCLES = cube_pkg::TIMEOUT_CYCLES,
   parameter logic [7:0] SYNC_BYTE      = cube_pkg::SYNC_BYTE,
   parameter int         ADDR_W         = $clog2(FRAME_BYTES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       mode_i,
   input  logic             err_clr_i,
   output logic             busy_o,
   output logic             err_overrun_o,
   uart_cmd_router_if.slave bus
);

   import cube_pkg::*;

   // one spare bit so the counter cannot wrap inside a frame
   localparam int             CW       = ADDR_W + 1;
   localparam logic [CW-1:0]  LAST_IDX = CW'(FRAME_BYTES - 1);

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic [7:0]        cfg_byte_q;
   logic              cfg_valid_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              commit_q;
   logic              abort_q;
   logic              err_q;

   logic in_stream;
   logic mode_ok;
   logic is_sync;
   logic tmr_clear;
   logic tmr_enable;
   logic tmr_expired;

   assign in_stream  = (state_q == ST_STREAM);
   assign mode_ok    = (mode_i == MODE_STREAM);
   assign is_sync    = (bus.rx_data == SYNC_BYTE);
   assign cnt_d      = cnt_q + CW'(1);
   assign tmr_clear  = !in_stream || bus.rx_valid;
   assign tmr_enable = in_stream && !bus.rx_valid;

   idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (tmr_clear),
      .enable_i (tmr_enable),
      .expired_o(tmr_expired)
   );

   // frame FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cfg_byte_q  <= '0;
         cfg_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         commit_q    <= 1'b0;
         abort_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cfg_valid_q <= 1'b0;
         wr_en_q     <= 1'b0;
         commit_q    <= 1'b0;
         abort_q     <= 1'b0;
         if (err_clr_i) begin
            err_q <= 1'b0;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (bus.rx_valid) begin
                  if (is_sync && mode_ok) begin
                     state_q <= ST_STREAM;
                     cnt_q   <= '0;
                  end else begin
                     cfg_byte_q  <= bus.rx_data;
                     cfg_valid_q <= 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (!mode_ok) begin
                  abort_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else if (bus.rx_valid) begin
                  if (bus.buf_ready) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= cnt_q[ADDR_W-1:0];
                     wr_data_q <= bus.rx_data;
                     cnt_q     <= cnt_d;
                     if (cnt_q == LAST_IDX) begin
                        commit_q <= 1'b1;
                        state_q  <= ST_IDLE;
                     end
                  end else begin
                     err_q   <= 1'b1;
                     abort_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else if (tmr_expired) begin
                  abort_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_byte     = cfg_byte_q;
   assign bus.cfg_valid    = cfg_valid_q;
   assign bus.buf_wr_en    = wr_en_q;
   assign bus.buf_wr_addr  = wr_addr_q;
   assign bus.buf_wr_data  = wr_data_q;
   assign bus.frame_commit = commit_q;
   assign bus.frame_abort  = abort_q;
   assign busy_o           = in_stream;
   assign err_overrun_o    = err_q;

endmodule

// File: tb/tb_uart_cmd_router.sv
// Directed bench for uart_cmd_router with a 16-cycle timeout.
// Inputs change on the falling edge; outputs sampled there too.
module tb_uart_cmd_router;

   localparam int TO = 16;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [3:0] mode    = 4'd0;
   logic       err_clr = 1'b0;
   logic       busy;
   logic       err;

   int total  = 0;
   int passes = 0;
   int fails  = 0;

   uart_cmd_router_if #(.ADDR_W(6)) bus ();

   uart_cmd_router #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode_i       (mode),
      .err_clr_i    (err_clr),
      .busy_o       (busy),
      .err_overrun_o(err),
      .bus          (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      bus.rx_valid = v;
      bus.rx_data  = d;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_cfg_valid"}, 32'(bus.cfg_valid), 0);
      chk({p, "_cfg_byte"}, 32'(bus.cfg_byte), 0);
      chk({p, "_wr_en"}, 32'(bus.buf_wr_en), 0);
      chk({p, "_wr_addr"}, 32'(bus.buf_wr_addr), 0);
      chk({p, "_wr_data"}, 32'(bus.buf_wr_data), 0);
      chk({p, "_commit"}, 32'(bus.frame_commit), 0);
      chk({p, "_abort"}, 32'(bus.frame_abort), 0);
      chk({p, "_busy"}, 32'(busy), 0);
      chk({p, "_err"}, 32'(err), 0);
   endtask

   // sync byte then 64 payload bytes, data = index ^ x
   task automatic full_frame(input logic [7:0] x);
      logic [7:0] b;
      tick();
      drive(1'b1, 8'hFF);
      tick();
      chk("sync_not_fwd", 32'(bus.cfg_valid), 0);
      chk("busy_in_frame", 32'(busy), 1);
      drive(1'b1, x);
      for (int i = 1; i <= 64; i++) begin
         tick();
         b = 8'(i - 1) ^ x;
         chk("frm_wr_en", 32'(bus.buf_wr_en), 1);
         chk("frm_wr_addr", 32'(bus.buf_wr_addr), 32'(i - 1));
         chk("frm_wr_data", 32'(bus.buf_wr_data), 32'(b));
         chk("frm_commit", 32'(bus.frame_commit), 32'(i == 64));
         chk("frm_abort", 32'(bus.frame_abort), 0);
         b = 8'(i) ^ x;
         drive(i < 64, b);
      end
      chk("frm_busy_after", 32'(busy), 0);
      tick();
      chk("frm_commit_pulse", 32'(bus.frame_commit), 0);
      chk("frm_wr_after", 32'(bus.buf_wr_en), 0);
   endtask

   initial begin
      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.buf_ready = 1'b1;

      // reset
      repeat (3) tick();
      chk_zero("rst");
      rst_n = 1'b1;

      // config byte forwarding
      tick();
      drive(1'b1, 8'h03);
      tick();
      chk("cfg_valid", 32'(bus.cfg_valid), 1);
      chk("cfg_byte", 32'(bus.cfg_byte), 32'h03);
      chk("cfg_no_wr", 32'(bus.buf_wr_en), 0);
      chk("cfg_busy", 32'(busy), 0);
      drive(1'b0, 8'h00);
      tick();
      chk("cfg_pulse", 32'(bus.cfg_valid), 0);

      // full frame, data = addr
      mode = 4'd3;
      full_frame(8'h00);

      // timeout after 10 bytes
      tick();
      drive(1'b1, 8'hFF);
      for (int i = 0; i < 10; i++) begin
         tick();
         drive(1'b1, 8'(8'h40 + i));
      end
      tick();
      chk("to_last_addr", 32'(bus.buf_wr_addr), 9);
      chk("to_last_data", 32'(bus.buf_wr_data), 32'h49);
      drive(1'b0, 8'h00);
      for (int k = 1; k < TO; k++) begin
         tick();
         chk("to_early_abort", 32'(bus.frame_abort), 0);
         chk("to_busy", 32'(busy), 1);
      end
      tick();
      chk("to_abort", 32'(bus.frame_abort), 1);
      chk("to_no_commit", 32'(bus.frame_commit), 0);
      chk("to_idle", 32'(busy), 0);
      tick();
      chk("to_abort_pulse", 32'(bus.frame_abort), 0);
      drive(1'b1, 8'h12);
      tick();
      chk("to_cfg_valid", 32'(bus.cfg_valid), 1);
      chk("to_cfg_byte", 32'(bus.cfg_byte), 32'h12);
      drive(1'b0, 8'h00);

      // overrun on byte 5, with a coinciding clear
      tick();
      drive(1'b1, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(1'b1, 8'(8'hA0 + i));
      end
      tick();
      chk("ovr_addr4", 32'(bus.buf_wr_addr), 4);
      drive(1'b1, 8'hA5);
      bus.buf_ready = 1'b0;
      err_clr = 1'b1;
      tick();
      chk("ovr_no_wr", 32'(bus.buf_wr_en), 0);
      chk("ovr_err_set_wins", 32'(err), 1);
      chk("ovr_abort", 32'(bus.frame_abort), 1);
      chk("ovr_idle", 32'(busy), 0);
      drive(1'b0, 8'h00);
      bus.buf_ready = 1'b1;
      err_clr = 1'b0;
      tick();
      chk("ovr_abort_pulse", 32'(bus.frame_abort), 0);
      chk("ovr_err_sticky", 32'(err), 1);
      err_clr = 1'b1;
      tick();
      chk("ovr_err_clr", 32'(err), 0);
      err_clr = 1'b0;

      // mode change mid-frame beats a same-cycle byte
      tick();
      drive(1'b1, 8'hFF);
      for (int i = 0; i < 20; i++) begin
         tick();
         drive(1'b1, 8'(i));
      end
      tick();
      chk("mode_addr19", 32'(bus.buf_wr_addr), 19);
      drive(1'b1, 8'h77);
      mode = 4'd1;
      tick();
      chk("mode_abort", 32'(bus.frame_abort), 1);
      chk("mode_no_wr", 32'(bus.buf_wr_en), 0);
      chk("mode_idle", 32'(busy), 0);
      chk("mode_no_cfg", 32'(bus.cfg_valid), 0);
      drive(1'b0, 8'h00);
      tick();
      drive(1'b1, 8'hFF);
      tick();
      chk("mode_ff_cfg_valid", 32'(bus.cfg_valid), 1);
      chk("mode_ff_cfg_byte", 32'(bus.cfg_byte), 32'hFF);
      chk("mode_ff_busy", 32'(busy), 0);
      drive(1'b0, 8'h00);

      // reset at byte 30, then a clean frame
      mode = 4'd3;
      tick();
      drive(1'b1, 8'hFF);
      for (int i = 0; i < 30; i++) begin
         tick();
         drive(1'b1, 8'(i));
      end
      tick();
      chk("mr_addr29", 32'(bus.buf_wr_addr), 29);
      drive(1'b1, 8'h1E);
      rst_n = 1'b0;
      tick();
      chk_zero("mr");
      rst_n = 1'b1;
      drive(1'b0, 8'h00);
      tick();
      chk("mr_no_abort", 32'(bus.frame_abort), 0);
      chk("mr_no_commit", 32'(bus.frame_commit), 0);
      full_frame(8'h5A);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
